// File: rtl/piso_shift_reg_4bit_pkg.sv
//------------------------------------------------------------------------------
// Module  : piso_shift_reg_4bit_pkg
// Brief   : Shared state encodings and default word width for the PISO/SIPO pair.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package piso_shift_reg_4bit_pkg;

    localparam int SR_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/piso_shift_reg_4bit_bit_counter.sv
//------------------------------------------------------------------------------
// Module  : bit_counter
// Brief   : Bit index counter with sync active-low clear, load-to-zero, enable
//           and terminal count at WIDTH-1 (wraps to zero on the next count).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic en,
    input  logic load_zero,
    output logic tc
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc = (cnt_q == LAST_IDX);

    always_comb begin
        cnt_d = cnt_q;
        if (load_zero) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/piso_shift_reg_4bit.sv
//------------------------------------------------------------------------------
// Module  : piso_shift_reg_4bit
// Brief   : Parallel-in serial-out shift register with valid/ready load and
//           bit-valid / last-bit markers. Optional trailing even-parity bit
//           when the macro PISO_PARITY_EN is defined.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module piso_shift_reg_4bit
    import piso_shift_reg_4bit_pkg::*;
#(
    parameter int WIDTH     = SR_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] par_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] shreg_shifted;
    logic             shreg_head;
    logic             cnt_tc;
    logic             in_shift;
    logic             shift_en;
    logic             accept;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shreg_head    = shreg_q[WIDTH-1];
            assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign shreg_head    = shreg_q[0];
            assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    assign in_shift  = (state_q == ST_SHIFT);
    assign shift_en  = in_shift && ser_en;
    assign accept    = load_valid && load_ready;
    assign busy      = (state_q != ST_IDLE);
    assign ser_valid = busy;

`ifdef PISO_PARITY_EN
    logic par_q;
    logic par_d;

    // Parity is latched at acceptance so the shifted-out register is not needed later.
    assign par_d      = accept ? ^par_in : par_q;
    assign ser_last   = (state_q == ST_PARITY);
    assign load_ready = (state_q == ST_IDLE);
    assign ser_out    = in_shift ? shreg_head : (ser_last ? par_q : 1'b0);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`else
    assign ser_last   = in_shift && cnt_tc;
    // Accepting during the final enabled bit gives gap-free back-to-back frames.
    assign load_ready = (state_q == ST_IDLE) || (shift_en && ser_last);
    assign ser_out    = in_shift ? shreg_head : 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ser_en && cnt_tc) begin
`ifdef PISO_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = accept ? ST_SHIFT : ST_IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                if (ser_en) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            shreg_d = par_in;
        end else if (shift_en) begin
            shreg_d = shreg_shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk       (clk),
        .clr_n     (clr_n),
        .en        (shift_en),
        .load_zero (accept),
        .tc        (cnt_tc)
    );

endmodule

`default_nettype wire

// File: tb/tb_piso_shift_reg_4bit.sv
//------------------------------------------------------------------------------
// Module  : tb_piso_shift_reg_4bit
// Brief   : Directed self-checking bench for piso_shift_reg_4bit (WIDTH=4,
//           MSB first); follows PISO_PARITY_EN when defined.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_piso_shift_reg_4bit;

`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk;
    logic       clr_n;
    logic [3:0] par_in;
    logic       load_valid;
    logic       load_ready;
    logic       ser_en;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_last;
    logic       busy;

    int checks;
    int errors;

    piso_shift_reg_4bit #(
        .WIDTH     (4),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .par_in     (par_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .ser_en     (ser_en),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_last   (ser_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Outputs are checked 1 ns after the inputs for the cycle are applied.
    task automatic expect_bit(input string tag, input logic o, input logic v,
                              input logic l, input logic b, input logic r);
        #1;
        chk({tag, ".ser_out"},    ser_out,    o);
        chk({tag, ".ser_valid"},  ser_valid,  v);
        chk({tag, ".ser_last"},   ser_last,   l);
        chk({tag, ".busy"},       busy,       b);
        chk({tag, ".load_ready"}, load_ready, r);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        clr_n      = 1'b0;
        par_in     = 4'b0000;
        load_valid = 1'b0;
        ser_en     = 1'b0;

        // 1: reset then idle
        tick(); tick();
        clr_n = 1'b1;
        expect_bit("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // 2: single frame 1011
        par_in = 4'b1011; load_valid = 1'b1; ser_en = 1'b1;
        tick();
        load_valid = 1'b0;
        expect_bit("f1011.b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("f1011.b1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("f1011.b2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("f1011.b3", 1'b1, 1'b1, !PAR, 1'b1, !PAR); tick();
        if (PAR) begin
            expect_bit("f1011.par", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        end
        expect_bit("f1011.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifndef PISO_PARITY_EN
        // 3: back-to-back 1100 then 0110 with no gap
        par_in = 4'b1100; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        expect_bit("b2b.b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("b2b.b1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("b2b.b2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        par_in = 4'b0110; load_valid = 1'b1;
        expect_bit("b2b.b3", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1); tick();
        load_valid = 1'b0;
        expect_bit("b2b.b4", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("b2b.b5", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("b2b.b6", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("b2b.b7", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1); tick();
        expect_bit("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        // 6: parity frame 0111, load_valid held throughout is ignored
        par_in = 4'b0111; load_valid = 1'b1;
        tick();
        par_in = 4'b1111;
        expect_bit("par.b0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("par.b1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("par.b2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("par.b3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("par.p",  1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        load_valid = 1'b0;
        tick();
        expect_bit("par.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // 4: stall 3 cycles on the 2nd bit of 1001; a load offered mid-stall is ignored
        par_in = 4'b1001; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        expect_bit("stall.b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        ser_en = 1'b0; par_in = 4'b0110; load_valid = 1'b1;
        expect_bit("stall.s1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("stall.s2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("stall.s3", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        ser_en = 1'b1; load_valid = 1'b0;
        expect_bit("stall.b1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("stall.b2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("stall.b3", 1'b1, 1'b1, !PAR, 1'b1, !PAR); tick();
        if (PAR) begin
            expect_bit("stall.par", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        end
        expect_bit("stall.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // 5: reset after 2 bits of 1111, then a clean 0001 frame
        par_in = 4'b1111; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        expect_bit("abort.b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("abort.b1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        expect_bit("abort.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        par_in = 4'b0001; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        expect_bit("f0001.b0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("f0001.b1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("f0001.b2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        expect_bit("f0001.b3", 1'b1, 1'b1, !PAR, 1'b1, !PAR); tick();
        if (PAR) begin
            expect_bit("f0001.par", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        end
        expect_bit("f0001.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset coinciding with a load request: the word is dropped
        clr_n = 1'b0; par_in = 4'b1010; load_valid = 1'b1;
        tick();
        clr_n = 1'b1; load_valid = 1'b0;
        expect_bit("rst_load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_bit("rst_load.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
